clock_ctrl: RTL
===============

# clock_ctrl

Mode and enable sequencer for the 24-hour digital clock. Turns a 1 Hz tick pulse and two debounced keys into single-cycle count enables for the seconds, minutes and hours BCD counters. Provides run, set-hour and set-minute modes, key auto-repeat, set-mode timeout and a display blink flag. Sits between the key/prescaler logic and the three cascaded BCD counters; it reads their values back to decide carries.

## Interface
- REPEAT_DLY, default 2: ticks `key_inc` must be held before auto-repeat starts (1..15).
- TIMEOUT, default 10: ticks without key activity in a set mode before returning to RUN (1..15).
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- tick  in  1  one-cycle 1 Hz pulse; consecutive pulses at least 3 cycles apart.
- key_mode  in  1  debounced mode key, active-high level, synchronous to clk.
- key_inc  in  1  debounced increment key, active-high level, synchronous to clk.
- sec  in  8  seconds counter value, packed BCD 00..59.
- min  in  8  minutes counter value, packed BCD 00..59.
- hour  in  8  hours counter value, packed BCD 00..23.
- en_sec  out  1  seconds count enable, one-cycle pulse.
- en_min  out  1  minutes count enable, one-cycle pulse.
- en_hour  out  1  hours count enable, one-cycle pulse.
- mode  out  2  00 RUN, 01 SET_HOUR, 10 SET_MIN; 11 never driven.
- blink  out  1  display blink phase for the field being set.

## Operation
- Reset: mode=RUN; en_sec, en_min, en_hour and blink are 0; the repeat and timeout counters are 0; the edge-detect history is 0.
- Keys are edge-detected: a press is a 0→1 transition of the registered level.
- State transitions on a key_mode press: RUN→SET_HOUR→SET_MIN→RUN.
- RUN behaviour:
  - On tick: en_sec=1.
  - en_min=1 if sec==8'h59.
  - en_hour=1 if sec==8'h59 and min==8'h59.
  - Counter wrap (23:59:59→00:00:00) belongs to the counters; the controller only pulses.
- SET_HOUR / SET_MIN behaviour:
  - Seconds are frozen (en_sec=0).
  - A key_inc press pulses en_hour (SET_HOUR) or en_min (SET_MIN) once.
  - There is no carry between fields: minutes 59→00 leaves hours unchanged.
- Auto-repeat, in set modes while key_inc is held:
  - The repeat counter counts ticks up to REPEAT_DLY and saturates.
  - Once saturated, every tick produces one increment pulse.
  - Releasing the key clears the counter.
- Timeout, in set modes:
  - The timeout counter increments on each tick and clears on any key press or while key_inc is held.
  - Reaching TIMEOUT forces RUN on the next cycle.
  - The timeout counter clears on every mode change.
- blink:
  - Toggles on each tick in set modes.
  - Forced to 0 in RUN and on any mode change.
- Simultaneous events:
  - key_mode press and key_inc press in the same cycle: the mode change wins and the inc press is dropped.
  - tick and a key_mode press in the same cycle: the tick is evaluated in the pre-transition state.
  - tick and a key_inc press in the same cycle in a set mode: exactly one increment pulse.
- Reset asserted mid-operation clears everything immediately, including any pulse in flight.

## Timing
- All outputs are registered.
- en_* rise exactly one cycle after the tick or key-press edge cycle and last exactly one cycle.
- Key latency is two cycles from a key level rising to the mode change or enable pulse: one cycle for edge registration, one for the output.
- Carry decisions use sec/min sampled in the tick cycle. The counters update on the edge that ends the en cycle, so sampled values are stable. This is why ticks must be ≥3 cycles apart.
- The mode output changes one cycle after the registered key_mode edge.

## Structure
- Shared package clock_pkg holds:
  - mode encodings MODE_RUN, MODE_SET_HOUR, MODE_SET_MIN;
  - BCD constants BCD_59 = 8'h59 and BCD_23 = 8'h23, reused by the counters.
- Sub-module key_edge: one-register rising-edge detector, instantiated for key_mode and key_inc.
- Remaining logic: mode FSM, two 4-bit tick counters (repeat, timeout), blink flop and the enable logic.

## Test plan
- RUN carry: sec=8'h59, min=8'h59, tick → en_sec, en_min and en_hour all 1 for one cycle; with sec=8'h12 → only en_sec.
- Mode cycling: three key_mode presses → mode 01, 10, 00; ticks in set modes give en_sec=0 and blink toggling; blink=0 after returning to RUN.
- Set hour with repeat: SET_HOUR, hold key_inc for 5 ticks with REPEAT_DLY=2 → 1 press pulse + 3 repeat pulses on en_hour, en_min and en_sec stay 0.
- Timeout: enter SET_MIN with no keys, TIMEOUT=10 → mode=00 one cycle after the 10th tick; holding key_inc prevents timeout.
- Collisions: key_mode and key_inc rising in the same cycle in SET_HOUR → mode=10 with no en_hour; tick coincident with the RUN→SET_HOUR press → en_sec pulses once.
- Async reset mid-pulse: assert rst during an en_min cycle → en_min and mode go to 0 immediately, without a clock edge.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared definitions for the 24-hour clock: mode encodings, BCD limits and widths.
package clock_pkg;

    localparam int unsigned MODE_W = 2;
    localparam int unsigned BCD_W  = 8;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [MODE_W-1:0] {
        MODE_RUN      = 2'b00,
        MODE_SET_HOUR = 2'b01,
        MODE_SET_MIN  = 2'b10
    } mode_e;

    localparam logic [BCD_W-1:0] BCD_59 = 8'h59;
    localparam logic [BCD_W-1:0] BCD_23 = 8'h23;

    // Mode key cycles RUN -> SET_HOUR -> SET_MIN -> RUN.
    function automatic mode_e next_mode(input mode_e cur);
        mode_e nxt;
        case (cur)
            MODE_RUN:      nxt = MODE_SET_HOUR;
            MODE_SET_HOUR: nxt = MODE_SET_MIN;
            default:       nxt = MODE_RUN;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/key_edge.sv
// Rising-edge detector for a debounced, clk-synchronous key level.
module key_edge (
    input  logic clk,
    input  logic rst,
    input  logic level_i,
    output logic press_o
);

    logic level_q;
    logic level_d;
    logic press_q;
    logic press_d;

    always_comb begin
        level_d = level_i;
        press_d = level_i & ~level_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/clock_ctrl.sv
// Mode sequencer and count-enable generator for the seconds/minutes/hours BCD counters.
module clock_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned REPEAT_DLY = 2,
    parameter int unsigned TIMEOUT    = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       key_mode,
    input  logic       key_inc,
    input  logic [7:0] sec,
    input  logic [7:0] min,
    input  logic [7:0] hour,
    output logic       en_sec,
    output logic       en_min,
    output logic       en_hour,
    output logic [1:0] mode,
    output logic       blink
);

    localparam logic [CNT_W-1:0] RPT_MAX = CNT_W'(REPEAT_DLY);
    localparam logic [CNT_W-1:0] TMO_MAX = CNT_W'(TIMEOUT);

    mode_e            mode_q;
    mode_e            mode_d;
    logic [CNT_W-1:0] rpt_q;
    logic [CNT_W-1:0] rpt_d;
    logic [CNT_W-1:0] tmo_q;
    logic [CNT_W-1:0] tmo_d;
    logic             blink_q;
    logic             blink_d;
    logic             en_sec_q;
    logic             en_sec_d;
    logic             en_min_q;
    logic             en_min_d;
    logic             en_hour_q;
    logic             en_hour_d;

    logic mode_press_c;
    logic inc_press_c;
    logic in_set_c;
    logic tmo_hit_c;
    logic mode_chg_c;
    logic rpt_fire_c;
    logic inc_ev_c;
    logic run_carry_min_c;
    logic run_carry_hour_c;
    logic unused_hour;

    // Hours wrap is handled by the hours counter itself.
    assign unused_hour = ^hour;

    key_edge u_mode_edge (
        .clk     (clk),
        .rst     (rst),
        .level_i (key_mode),
        .press_o (mode_press_c)
    );

    key_edge u_inc_edge (
        .clk     (clk),
        .rst     (rst),
        .level_i (key_inc),
        .press_o (inc_press_c)
    );

    assign in_set_c   = (mode_q != MODE_RUN);
    assign tmo_hit_c  = in_set_c && (tmo_q >= TMO_MAX);
    assign mode_chg_c = (mode_d != mode_q);

    // Auto-repeat fires on each tick once the hold counter has saturated.
    assign rpt_fire_c = in_set_c && tick && key_inc && (rpt_q == RPT_MAX);
    // A coincident mode press swallows the increment press.
    assign inc_ev_c   = in_set_c && ((inc_press_c && !mode_press_c) || rpt_fire_c);

    assign run_carry_min_c  = (sec == BCD_59);
    assign run_carry_hour_c = (sec == BCD_59) && (min == BCD_59);

    // Mode state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q <= MODE_RUN;
        end else begin
            mode_q <= mode_d;
        end
    end

    // Next-state: timeout has priority over a mode press.
    always_comb begin
        mode_d = mode_q;
        if (tmo_hit_c) begin
            mode_d = MODE_RUN;
        end else if (mode_press_c) begin
            mode_d = next_mode(mode_q);
        end
    end

    // Enables, blink and tick counters; tick is judged in the pre-transition mode.
    always_comb begin
        en_sec_d  = 1'b0;
        en_min_d  = 1'b0;
        en_hour_d = 1'b0;
        blink_d   = blink_q;
        rpt_d     = rpt_q;
        tmo_d     = tmo_q;

        case (mode_q)
            MODE_RUN: begin
                en_sec_d  = tick;
                en_min_d  = tick && run_carry_min_c;
                en_hour_d = tick && run_carry_hour_c;
            end
            MODE_SET_HOUR: en_hour_d = inc_ev_c;
            MODE_SET_MIN:  en_min_d  = inc_ev_c;
            default: ;
        endcase

        if (!in_set_c || mode_chg_c) begin
            blink_d = 1'b0;
        end else if (tick) begin
            blink_d = ~blink_q;
        end

        if (!in_set_c || mode_chg_c || !key_inc) begin
            rpt_d = '0;
        end else if (tick && (rpt_q < RPT_MAX)) begin
            rpt_d = rpt_q + CNT_W'(1);
        end

        if (!in_set_c || mode_chg_c || mode_press_c || inc_press_c || key_inc) begin
            tmo_d = '0;
        end else if (tick && (tmo_q < TMO_MAX)) begin
            tmo_d = tmo_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_sec_q  <= 1'b0;
            en_min_q  <= 1'b0;
            en_hour_q <= 1'b0;
            blink_q   <= 1'b0;
            rpt_q     <= '0;
            tmo_q     <= '0;
        end else begin
            en_sec_q  <= en_sec_d;
            en_min_q  <= en_min_d;
            en_hour_q <= en_hour_d;
            blink_q   <= blink_d;
            rpt_q     <= rpt_d;
            tmo_q     <= tmo_d;
        end
    end

    assign en_sec  = en_sec_q;
    assign en_min  = en_min_q;
    assign en_hour = en_hour_q;
    assign mode    = mode_q;
    assign blink   = blink_q;

endmodule
